exercicio7_paridade_serial: RTL
===============================

# exercicio7_paridade_serial

Serial parity checker that sits directly downstream of the two-input XOR stage (`exercicio6`) and reuses it as its accumulation step. The checker accepts a bit-serial frame of N data bits followed by one received parity bit. It folds each data bit into a running XOR and compares the result against the received parity. It then reports the computed parity, a mismatch flag and a one-cycle completion pulse per frame.

## Interface
- `N`, default 8: data bits per frame. Legal range is N ≥ 1.
- `ODD`, default 0: parity sense. 0 selects even parity, so expected parity = XOR of the data bits. 1 selects odd parity, so expected parity = inverted XOR.
- `CW`, default `$clog2(N+1)`: counter width. It is a derived localparam, not overridable.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `a`, input, 1: serial data or parity bit.
- `a_valid`, input, 1: `a` is sampled only when this is 1.
- `f`, output, 1: computed expected parity of the last completed frame.
- `err`, output, 1: 1 when the received parity bit differed from `f` in the last completed frame.
- `done`, output, 1: one-cycle pulse marking a completed frame.
- `cnt`, output, CW: number of data bits accepted in the current frame.

## Operation
- **State machine.** States are IDLE, DATA and CHECK. The running-parity register is `acc`.
- **IDLE.** `acc=0` and `cnt=0`.
  - On `a_valid`: `acc←a`, `cnt←1`.
  - Next state is CHECK if N==1, otherwise DATA.
- **DATA.** On `a_valid`: `acc←acc^a` (computed through `exercicio6`) and `cnt←cnt+1`.
  - When the bit just accepted makes `cnt==N`, next state is CHECK.
- **CHECK.** The next valid bit is the received parity bit.
  - On `a_valid`: `f←acc^ODD`, `err←a^acc^ODD`, `done←1`, `acc←0`, `cnt←0`, next state IDLE.
- **Gaps.** While `a_valid=0` in any state: no state change and no counter change. `done` is 0 in that cycle.
- **Result hold.** `f` and `err` hold the last frame's result until the next `done`. They change only in the cycle `done` rises.
- **Counter range.** `cnt` never exceeds N. It reads N while in CHECK.
- **Reset.** On `rst=1`: state IDLE, `acc=0`, `cnt=0`, `f=0`, `err=0`, `done=0`.
  - Reset overrides `a_valid` in the same cycle.
  - A reset mid-frame discards the partial frame and produces no `done`.
- **Back-to-back frames.** A valid bit in the cycle `done` is high is accepted by IDLE as bit 0 of the next frame. Back-to-back frames need no bubble.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Latency is 1 cycle: `done`, `f` and `err` are valid in the cycle after the parity bit is sampled.
- `done` is high for exactly one cycle per frame.
- Minimum frame time is N+1 cycles with `a_valid` held at 1. The resulting throughput is one frame per N+1 cycles.
- `cnt` updates on the same edge that samples the bit.

## Structure
- **Shared header `exercicio_defs.vh`:**
  - 2-bit state encodings: `ST_IDLE=2'd0`, `ST_DATA=2'd1`, `ST_CHECK=2'd2`.
  - Parity-sense constants: `PAR_EVEN=0`, `PAR_ODD=1`.
- **Sub-module.** Exactly one natural sub-module, `exercicio6`, instanced once with inputs (`acc`, `a`) and its output used as the next `acc`.
- **Encoding 2'd3.** Unreachable. If ever entered, it returns to IDLE on the next edge.

## Test plan
All scenarios use N=8 and ODD=0 unless noted.
1. **Good even frame.** Data 1,0,1,1,0,0,1,0, then parity 0, `a_valid` held at 1.
   - `done`=1 exactly at cycle 10 after the first bit, with `f=0` and `err=0`.
   - `cnt` steps 1..8.
2. **Bad parity.** Same data, parity bit 1.
   - `done`=1 with `f=0` and `err=1`.
   - `f` and `err` then hold until the next frame.
3. **Gaps.** Data 1,1,1,0,0,0,0,0 with `a_valid=0` for 3 cycles after bits 2 and 5, then parity 1.
   - `cnt` and `acc` frozen during each gap.
   - `done` with `f=1` and `err=0`, arriving 6 cycles later than with no gaps.
4. **Reset mid-frame.**
   - `rst` after 5 bits: `cnt=0`, `f=0`, `err=0`, no `done`.
   - A fresh good frame afterwards completes normally.
5. **Back-to-back frames.** Two frames with no idle between them: all-ones data plus parity 0, then 0x01 pattern plus parity 0.
   - Two `done` pulses 9 cycles apart.
   - Second frame reports `f=1` and `err=1`.
6. **Odd parity, N=1.** ODD=1, N=1, bit 0 then parity 1.
   - `done` with `f=1` and `err=0`.
   - Repeating with parity 0 gives `err=1`.

Source files
------------

// File: rtl/exercicio7_paridade_serial_pkg.sv
// Shared types and constants for the serial parity checker.
package exercicio7_paridade_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/exercicio6.sv
// Two-input XOR stage; used by the parity checker as its accumulation step.
module exercicio6 (
  input  logic a,
  input  logic b,
  output logic f
);

  assign f = a ^ b;

endmodule

// File: rtl/exercicio7_paridade_serial.sv
// Serial parity checker: N data bits followed by one received parity bit,
// reporting computed parity, mismatch flag and a one-cycle done pulse.
//
// state    | meaning
// ST_IDLE  | waiting for bit 0 of a frame; acc and cnt are zero
// ST_DATA  | accumulating data bits 1..N-1 into acc
// ST_CHECK | all N data bits taken; next valid bit is the received parity
module exercicio7_paridade_serial
  import exercicio7_paridade_serial_pkg::*;
#(
  parameter int N   = 8,
  parameter int ODD = PAR_EVEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a,
  input  logic                       a_valid,
  output logic                       f,
  output logic                       err,
  output logic                       done,
  output logic [$clog2(N+1)-1:0]     cnt
);

  localparam int   CW      = $clog2(N + 1);
  localparam logic ODD_BIT = (ODD == PAR_ODD);

  state_t          state, state_nxt;
  logic            acc, acc_nxt;
  logic            xor_out;
  logic [CW-1:0]   cnt_nxt, cnt_inc;
  logic            f_nxt, err_nxt, done_nxt;

  exercicio6 u_xor (
    .a (acc),
    .b (a),
    .f (xor_out)
  );

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    f_nxt     = f;
    err_nxt   = err;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_nxt = 1'b0;
        cnt_nxt = '0;
        if (a_valid) begin
          acc_nxt   = a;
          cnt_nxt   = CW'(1);
          state_nxt = (N == 1) ? ST_CHECK : ST_DATA;
        end
      end
      ST_DATA: begin
        if (a_valid) begin
          acc_nxt = xor_out;
          cnt_nxt = cnt_inc;
          if (cnt_inc == CW'(N)) state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (a_valid) begin
          f_nxt     = acc ^ ODD_BIT;
          err_nxt   = a ^ acc ^ ODD_BIT;
          done_nxt  = 1'b1;
          acc_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      // the spare encoding falls back to a clean idle
      default: begin
        acc_nxt   = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= 1'b0;
      cnt   <= '0;
      f     <= 1'b0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      f     <= f_nxt;
      err   <= err_nxt;
      done  <= done_nxt;
    end
  end

endmodule
